risc16_imem_loader: RTL

Program loader that fills the RISC-16 instruction memory from a byte stream and holds the core in reset until the image is complete. It sits between an external byte source (UART receiver or bench driver) and the instruction memory write port. It drives the core reset so the fetch side (6-bit `instruction_addr`) only starts reading after the last word is written.

---
 rtl/risc16_pkg.sv | 28 ++
 rtl/risc16_byte_pair.sv | 37 +++
 rtl/risc16_imem_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - shared types and constants for the RISC-16 instruction memory loader
// Optional checksum state is present only with RISC16_LOADER_CHECKSUM_EN.
package risc16_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int WORD_W_DEF = 16;
  localparam int DEPTH_DEF  = 64;

  // Header byte 0 stands for a full 64-word image; anything above 64 is rejected.
  localparam int HDR_ZERO_WORDS = 64;
  localparam int HDR_LIMIT      = 64;

  typedef enum logic [2:0] {
    S_HDR = 3'd0,
    S_HI  = 3'd1,
    S_LO  = 3'd2,
`ifdef RISC16_LOADER_CHECKSUM_EN
    S_CHK = 3'd3,
`endif
    S_RUN = 3'd4,
    S_ERR = 3'd5
  } loader_state_t;

  function automatic logic [8:0] hdr_words(input logic [7:0] hdr);
    return (hdr == 8'd0) ? 9'(HDR_ZERO_WORDS) : {1'b0, hdr};
  endfunction

endpackage

// File: rtl/risc16_byte_pair.sv
// rtl/risc16_byte_pair.sv - assembles {hi,lo} byte pairs into registered instruction memory writes
module risc16_byte_pair
  import risc16_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_load,
  input  logic              lo_load,
  input  logic [7:0]        byte_data,
  input  logic [ADDR_W-1:0] word_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata
);

  logic [7:0] hi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= lo_load;
      if (hi_load) hi_q <= byte_data;
      if (lo_load) begin
        mem_addr  <= word_addr;
        mem_wdata <= WORD_W'({hi_q, byte_data});
      end
    end
  end

endmodule

// File: rtl/risc16_imem_loader.sv
// rtl/risc16_imem_loader.sv - byte-stream loader for RISC-16 instruction memory, holds core in reset until loaded
// Define RISC16_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module risc16_imem_loader
  import risc16_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] word_cnt_q;
  logic [ADDR_W-1:0] last_idx_q;
  logic              busy;
  logic              accept;
  logic              hi_load;
  logic              lo_load;
  logic              last_word;
  logic              done_d;
  logic [8:0]        hdr_words_w;
  logic              hdr_ok;

`ifdef RISC16_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
`endif

  assign hdr_words_w = hdr_words(in_data);
  assign hdr_ok      = (hdr_words_w <= 9'(DEPTH));
  assign last_word   = (word_cnt_q == last_idx_q);

  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_HDR, S_HI, S_LO: busy = 1'b1;
`ifdef RISC16_LOADER_CHECKSUM_EN
      S_CHK:             busy = 1'b1;
`endif
      default:           busy = 1'b0;
    endcase
  end

  assign in_ready = busy & ~load_req & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    hi_load = 1'b0;
    lo_load = 1'b0;
    case (state_q)
      S_HDR: if (accept) state_d = hdr_ok ? S_HI : S_ERR;
      S_HI: begin
        if (accept) begin
          hi_load = 1'b1;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          lo_load = 1'b1;
          if (!last_word) state_d = S_HI;
`ifdef RISC16_LOADER_CHECKSUM_EN
          else            state_d = S_CHK;
`else
          else            state_d = S_RUN;
`endif
        end
      end
`ifdef RISC16_LOADER_CHECKSUM_EN
      S_CHK: if (accept) state_d = (in_data == csum_q) ? S_RUN : S_ERR;
`endif
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR;
    endcase
    if (load_req) state_d = S_HDR;
  end

  // Without the checksum, release waits one cycle past the final write strobe.
`ifdef RISC16_LOADER_CHECKSUM_EN
  assign done_d = (state_d == S_RUN);
`else
  assign done_d = (state_q == S_RUN) && (state_d == S_RUN);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      done    <= 1'b0;
      cpu_rst <= 1'b1;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      cpu_rst <= ~done_d;
      err     <= (state_d == S_ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load_req) begin
      word_cnt_q <= '0;
      last_idx_q <= '0;
    end else if (state_q == S_HDR && accept) begin
      word_cnt_q <= '0;
      last_idx_q <= ADDR_W'(hdr_words_w - 9'd1);
    end else if (lo_load && !last_word) begin
      word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

`ifdef RISC16_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || load_req) csum_q <= '0;
    else if (accept)     csum_q <= csum_q ^ in_data;
  end
`endif

  risc16_byte_pair #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_byte_pair (
    .clk       (clk),
    .rst       (rst),
    .hi_load   (hi_load),
    .lo_load   (lo_load),
    .byte_data (in_data),
    .word_addr (word_cnt_q),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule
